tlb_maint: RTL and testbench
============================

TLB_MAINT -- requirements
Module: tlb_maint

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL use TLBIDLEN, tlb_entry_t and csr_tlb_rdata field semantics from definitions.svh; TLBNUM = 2**TLBIDLEN.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  maintenance request present.
REQ-006 req_ready  out  1  block idle, request accepted when req_valid && req_ready.
REQ-007 req_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV, 5..7 reserved.
REQ-008 inv_op  in  5  INVTLB op field, sampled at accept.
REQ-009 inv_asid  in  10  INVTLB asid operand, sampled at accept.
REQ-010 inv_va  in  32  INVTLB va operand, sampled at accept; only bits 31:13 used.
REQ-011 done  out  1  one-cycle pulse, operation complete.
REQ-012 csr_tlbidx  in  TLBIDLEN  CSR TLBIDX.Index.
REQ-013 csr_asid  in  10  CSR ASID.ASID; used as search ASID.
REQ-014 csr_tlb_rdata  in  tlb_entry_t  entry image from CSRs (vppn = search key).
REQ-015 csr_tlbsrch_we / csr_tlbsrch_found / csr_tlbsrch_index  out  1/1/TLBIDLEN  search result to CSR.
REQ-016 csr_tlb_we / csr_tlb_wdata  out  1/tlb_entry_t  TLBRD result to CSR.
REQ-017 tlb_ridx  out  TLBIDLEN  array read index; tlb_rdata  in  tlb_entry_t  combinational read data.
REQ-018 tlb_we / tlb_widx / tlb_wdata  out  1/TLBIDLEN/tlb_entry_t  array write port, written at clock edge.

Function
REQ-019 The FSM SHALL have the states IDLE, SRCH, RD, WR, INV and DONE; req_ready SHALL be 1 only in IDLE.
REQ-020 On accept, the op and operands SHALL be latched, the walk counter cnt SHALL be set to 0, and the next state SHALL be SRCH, RD, WR (ops 2 and 3) or INV; reserved ops SHALL go directly to DONE.
REQ-021 The entry match function SHALL be e && (g || asid==key_asid) && (ps==12 ? vppn==key : vppn[18:9]==key[18:9]).
REQ-022 In SRCH, tlb_ridx SHALL equal cnt, one entry SHALL be examined per cycle, and key SHALL be csr_tlb_rdata.vppn with key_asid = csr_asid.
- On the first hit: csr_tlbsrch_we=1, found=1, index=cnt for one cycle, then DONE.
- On a miss at cnt==TLBNUM-1: csr_tlbsrch_we=1, found=0, then DONE.
- Latency: hit at index k takes k+1 cycles.
REQ-023 RD SHALL take one cycle with tlb_ridx=csr_tlbidx, csr_tlb_we=1 and csr_tlb_wdata=tlb_rdata unmodified, then go to DONE.
REQ-024 WR SHALL take one cycle with tlb_we=1 and tlb_wdata=csr_tlb_rdata, then go to DONE.
- tlb_widx SHALL be csr_tlbidx for op 2.
- tlb_widx SHALL be fill_ptr for op 3.
REQ-025 fill_ptr SHALL be a TLBIDLEN-bit counter that increments every cycle and wraps from TLBNUM-1 to 0.
REQ-026 INV SHALL visit every index 0..TLBNUM-1, one per cycle with tlb_ridx=cnt, and SHALL always take TLBNUM cycles.
- When the entry is selected, tlb_we=1, tlb_widx=cnt and tlb_wdata = tlb_rdata with e=0.
REQ-027 INV entry selection by inv_op:
- 0,1: all entries.
- 2: g=1.
- 3: g=0.
- 4: g=0 && asid==inv_asid.
- 5: g=0 && asid==inv_asid && VA match.
- 6: (g || asid==inv_asid) && VA match.
- >=7: none; INV is still walked.
- VA match uses the REQ-021 ps rule with key = inv_va[31:13], and requires e=1.
REQ-028 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-029 csr_tlbsrch_we, csr_tlb_we and tlb_we SHALL each be asserted only in the cycles specified above; at most one of them SHALL be asserted per cycle.
REQ-030 req_valid outside IDLE SHALL be ignored; the requester SHALL hold it until accepted.
REQ-031 cnt SHALL be TLBIDLEN+1 bits wide to avoid aliasing at the terminal count.

Reset
REQ-032 While resetn=0, the block SHALL hold state=IDLE, cnt=0 and fill_ptr=0, and SHALL drive req_ready=1, done=0, all write enables=0 and all index/data outputs=0.
REQ-033 Reset asserted mid-SRCH or mid-INV SHALL abort the walk immediately, with no further writes and no done.

Verification
REQ-034 SRCH, entry 5 = {e=1, g=0, asid=3, ps=12, vppn=0x12345}, csr_asid=3, key=0x12345 -> csr_tlbsrch_we with found=1, index=5 in the 6th cycle after accept, then done.
REQ-035 SRCH, same array, csr_asid=4 -> found=0 in cycle TLBNUM, no array writes.
REQ-036 FILL issued twice, 3 cycles apart, fill_ptr=0 at first accept -> the two writes land at distinct indices that match the fill_ptr values at their write cycles.
REQ-037 INV op 5, inv_asid=3, inv_va=0x2468A000, entries {g=0, asid=3, vppn=0x12345} and {g=1, same vppn} -> only the g=0 entry is rewritten with e=0; done after TLBNUM+1 cycles.
REQ-038 RD with csr_tlbidx=7 -> csr_tlb_we=1 with csr_tlb_wdata equal to entry 7 for one cycle; reserved req_op=6 -> done in the next cycle with no enables.
REQ-039 resetn pulsed low during INV at cnt=4 -> no write at cnt>=4, no done, req_ready=1 after release.

Source files
------------

// File: rtl/tlb_maint.sv
// TLB maintenance sequencer: search, read, write/fill and INVTLB walks over a
// TLBNUM-entry array with a single combinational read port and one write port.
package tlb_maint_pkg;
    localparam int TLBIDLEN = 4;
    localparam int TLBNUM   = 2 ** TLBIDLEN;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        logic [19:0] ppn0;
        logic [19:0] ppn1;
    } tlb_entry_t;
endpackage

// state | meaning
// IDLE  | ready for a request
// SRCH  | walk entries cnt=0.. looking for the first match
// RD    | copy entry csr_tlbidx to the CSR image
// WR    | write CSR image to csr_tlbidx (WR) or fill_ptr (FILL)
// INV   | visit every entry, clear e on the selected ones
// DONE  | one-cycle completion pulse
module tlb_maint
    import tlb_maint_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [4:0]          inv_op,
    input  logic [9:0]          inv_asid,
    input  logic [31:0]         inv_va,
    output logic                done,
    input  logic [TLBIDLEN-1:0] csr_tlbidx,
    input  logic [9:0]          csr_asid,
    input  tlb_entry_t          csr_tlb_rdata,
    output logic                csr_tlbsrch_we,
    output logic                csr_tlbsrch_found,
    output logic [TLBIDLEN-1:0] csr_tlbsrch_index,
    output logic                csr_tlb_we,
    output tlb_entry_t          csr_tlb_wdata,
    output logic [TLBIDLEN-1:0] tlb_ridx,
    input  tlb_entry_t          tlb_rdata,
    output logic                tlb_we,
    output logic [TLBIDLEN-1:0] tlb_widx,
    output tlb_entry_t          tlb_wdata
);
    localparam int CNT_W = TLBIDLEN + 1;

    typedef enum logic [2:0] {IDLE, SRCH, RD, WR, INV, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [TLBIDLEN-1:0] fill_ptr;
    logic                fill_q;
    logic [4:0]          inv_op_q;
    logic [9:0]          inv_asid_q;
    logic [18:0]         inv_vpn_q;
    logic                accept;
    logic                cnt_last;
    logic                srch_hit;
    logic                inv_sel;
    logic                inv_va_ok;
    logic                unused_va;

    // Low page-offset bits of the INVTLB address never take part in matching.
    assign unused_va = ^inv_va[12:0];

    function automatic logic vpn_match(tlb_entry_t ent, logic [18:0] key);
        return (ent.ps == 6'd12) ? (ent.vppn == key) : (ent.vppn[18:9] == key[18:9]);
    endfunction

    assign accept    = (state == IDLE) && req_valid;
    assign cnt_last  = (cnt == CNT_W'(TLBNUM - 1));
    assign srch_hit  = tlb_rdata.e && (tlb_rdata.g || (tlb_rdata.asid == csr_asid))
                       && vpn_match(tlb_rdata, csr_tlb_rdata.vppn);
    assign inv_va_ok = tlb_rdata.e && vpn_match(tlb_rdata, inv_vpn_q);

    always_comb begin
        inv_sel = 1'b0;
        case (inv_op_q)
            5'd0, 5'd1: inv_sel = 1'b1;
            5'd2:       inv_sel = tlb_rdata.g;
            5'd3:       inv_sel = !tlb_rdata.g;
            5'd4:       inv_sel = !tlb_rdata.g && (tlb_rdata.asid == inv_asid_q);
            5'd5:       inv_sel = !tlb_rdata.g && (tlb_rdata.asid == inv_asid_q) && inv_va_ok;
            5'd6:       inv_sel = (tlb_rdata.g || (tlb_rdata.asid == inv_asid_q)) && inv_va_ok;
            default:    inv_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            fill_ptr   <= '0;
            fill_q     <= 1'b0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vpn_q  <= '0;
        end else begin
            state    <= state_nxt;
            fill_ptr <= fill_ptr + TLBIDLEN'(1);
            if (accept) begin
                cnt        <= '0;
                fill_q     <= (req_op == 3'd3);
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vpn_q  <= inv_va[31:13];
            end else if (state == SRCH || state == INV) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        3'd0:       state_nxt = SRCH;
                        3'd1:       state_nxt = RD;
                        3'd2, 3'd3: state_nxt = WR;
                        3'd4:       state_nxt = INV;
                        default:    state_nxt = DONE;
                    endcase
                end
            end
            SRCH:    if (srch_hit || cnt_last) state_nxt = DONE;
            RD:      state_nxt = DONE;
            WR:      state_nxt = DONE;
            INV:     if (cnt_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready         = 1'b0;
        done              = 1'b0;
        csr_tlbsrch_we    = 1'b0;
        csr_tlbsrch_found = 1'b0;
        csr_tlbsrch_index = '0;
        csr_tlb_we        = 1'b0;
        csr_tlb_wdata     = '0;
        tlb_ridx          = '0;
        tlb_we            = 1'b0;
        tlb_widx          = '0;
        tlb_wdata         = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            SRCH: begin
                tlb_ridx = cnt[TLBIDLEN-1:0];
                if (srch_hit || cnt_last) begin
                    csr_tlbsrch_we    = 1'b1;
                    csr_tlbsrch_found = srch_hit;
                    csr_tlbsrch_index = cnt[TLBIDLEN-1:0];
                end
            end
            RD: begin
                tlb_ridx      = csr_tlbidx;
                csr_tlb_we    = 1'b1;
                csr_tlb_wdata = tlb_rdata;
            end
            WR: begin
                tlb_we    = 1'b1;
                tlb_widx  = fill_q ? fill_ptr : csr_tlbidx;
                tlb_wdata = csr_tlb_rdata;
            end
            INV: begin
                tlb_ridx = cnt[TLBIDLEN-1:0];
                if (inv_sel) begin
                    tlb_we      = 1'b1;
                    tlb_widx    = cnt[TLBIDLEN-1:0];
                    tlb_wdata   = tlb_rdata;
                    tlb_wdata.e = 1'b0;
                end
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_tlb_maint.sv
// Scoreboard bench for tlb_maint: a reference model predicts every enable pulse
// (kind, cycle, index, data) and a negedge monitor checks what the DUT presents.
module tb_tlb_maint;
    import tlb_maint_pkg::*;

    localparam int K_SRCH = 0, K_RD = 1, K_WR = 2, K_DONE = 3;

    typedef struct {
        int         kind;
        int         cyc;
        int         idx;
        logic       found;
        tlb_entry_t data;
    } exp_t;

    logic                clk, resetn;
    logic                req_valid, req_ready;
    logic [2:0]          req_op;
    logic [4:0]          inv_op;
    logic [9:0]          inv_asid;
    logic [31:0]         inv_va;
    logic                done;
    logic [TLBIDLEN-1:0] csr_tlbidx;
    logic [9:0]          csr_asid;
    tlb_entry_t          csr_tlb_rdata;
    logic                csr_tlbsrch_we, csr_tlbsrch_found;
    logic [TLBIDLEN-1:0] csr_tlbsrch_index;
    logic                csr_tlb_we;
    tlb_entry_t          csr_tlb_wdata;
    logic [TLBIDLEN-1:0] tlb_ridx;
    tlb_entry_t          tlb_rdata;
    logic                tlb_we;
    logic [TLBIDLEN-1:0] tlb_widx;
    tlb_entry_t          tlb_wdata;

    tlb_entry_t mem     [TLBNUM];
    tlb_entry_t ref_mem [TLBNUM];
    exp_t       q[$];
    int         cyc;
    int         n_checks = 0;
    int         n_pass   = 0;

    logic [18:0] vpool [4] = '{19'h12345, 19'h12355, 19'h0ABCD, 19'h7FFFF};
    logic [9:0]  apool [3] = '{10'd3, 10'd4, 10'd5};

    tlb_maint dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .done(done),
        .csr_tlbidx(csr_tlbidx), .csr_asid(csr_asid), .csr_tlb_rdata(csr_tlb_rdata),
        .csr_tlbsrch_we(csr_tlbsrch_we), .csr_tlbsrch_found(csr_tlbsrch_found),
        .csr_tlbsrch_index(csr_tlbsrch_index),
        .csr_tlb_we(csr_tlb_we), .csr_tlb_wdata(csr_tlb_wdata),
        .tlb_ridx(tlb_ridx), .tlb_rdata(tlb_rdata),
        .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wdata(tlb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tlb_rdata = mem[tlb_ridx];

    always @(posedge clk) if (resetn && tlb_we) mem[tlb_widx] <= tlb_wdata;

    // Cycles since reset release; equals the DUT's fill pointer modulo TLBNUM.
    always @(posedge clk or negedge resetn)
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, msg);
    endtask

    function automatic bit va_ok(tlb_entry_t t, logic [18:0] key);
        if (t.ps == 6'd12) return t.vppn == key;
        return t.vppn[18:9] == key[18:9];
    endfunction

    function automatic bit srch_match(tlb_entry_t t, logic [18:0] key, logic [9:0] asid);
        return t.e && (t.g || t.asid == asid) && va_ok(t, key);
    endfunction

    function automatic bit inv_pick(tlb_entry_t t, int iop, logic [9:0] ia, logic [18:0] ivpn);
        bit va;
        va = t.e && va_ok(t, ivpn);
        case (iop)
            0, 1:    return 1'b1;
            2:       return t.g;
            3:       return !t.g;
            4:       return !t.g && t.asid == ia;
            5:       return !t.g && t.asid == ia && va;
            6:       return (t.g || t.asid == ia) && va;
            default: return 1'b0;
        endcase
    endfunction

    function automatic tlb_entry_t rand_entry(bit valid_ok);
        tlb_entry_t t;
        t.vppn = vpool[$urandom_range(0, 3)];
        t.ps   = ($urandom_range(0, 1) == 0) ? 6'd12 : 6'd21;
        t.g    = ($urandom_range(0, 3) == 0);
        t.asid = apool[$urandom_range(0, 2)];
        t.e    = valid_ok && ($urandom_range(0, 3) != 0);
        t.ppn0 = 20'($urandom);
        t.ppn1 = 20'($urandom);
        return t;
    endfunction

    task automatic load_mem(input bit valid_ok);
        for (int i = 0; i < TLBNUM; i++) begin
            mem[i]     = rand_entry(valid_ok);
            ref_mem[i] = mem[i];
        end
    endtask

    task automatic push(input int kind, input int c, input int idx, input logic found,
                        input tlb_entry_t d);
        exp_t ev;
        ev.kind = kind; ev.cyc = c; ev.idx = idx; ev.found = found; ev.data = d;
        q.push_back(ev);
    endtask

    always @(negedge clk) begin
        exp_t ev;
        int   nen, kind;
        bit   ok;
        if (resetn) begin
            nen = int'(csr_tlbsrch_we) + int'(csr_tlb_we) + int'(tlb_we) + int'(done);
            kind = csr_tlbsrch_we ? K_SRCH : csr_tlb_we ? K_RD : tlb_we ? K_WR : K_DONE;
            if (nen > 1) begin
                chk(1'b0, "one_enable", $sformatf("cyc %0d got %0d enables, need 1", cyc, nen));
                void'(q.pop_front());
            end else if (nen == 1) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected", $sformatf("cyc %0d kind %0d, none expected", cyc, kind));
                end else begin
                    ev = q.pop_front();
                    ok = (kind == ev.kind) && (cyc == ev.cyc);
                    if (ok && kind == K_SRCH)
                        ok = (csr_tlbsrch_found == ev.found) &&
                             (!ev.found || int'(csr_tlbsrch_index) == ev.idx);
                    if (ok && kind == K_RD) ok = (csr_tlb_wdata == ev.data);
                    if (ok && kind == K_WR)
                        ok = (int'(tlb_widx) == ev.idx) && (tlb_wdata == ev.data);
                    chk(ok, "event", $sformatf(
                        "got kind %0d cyc %0d found %0b sidx %0d widx %0d wd %h rd %h, need kind %0d cyc %0d found %0b idx %0d data %h",
                        kind, cyc, csr_tlbsrch_found, csr_tlbsrch_index, tlb_widx, tlb_wdata,
                        csr_tlb_wdata, ev.kind, ev.cyc, ev.found, ev.idx, ev.data));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        chk(req_ready && !done && !csr_tlbsrch_we && !csr_tlb_we && !tlb_we &&
            tlb_ridx == 0 && tlb_widx == 0 && tlb_wdata == '0 && csr_tlb_wdata == '0 &&
            csr_tlbsrch_index == 0 && !csr_tlbsrch_found, name,
            $sformatf("ready %0b done %0b we %0b%0b%0b ridx %0d widx %0d, need ready=1 rest 0",
                      req_ready, done, csr_tlbsrch_we, csr_tlb_we, tlb_we, tlb_ridx, tlb_widx));
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] ia,
                         input logic [31:0] iva, input logic [TLBIDLEN-1:0] idx,
                         input logic [9:0] asid, input tlb_entry_t cd, input int abort_at);
        int a, hit, widx, n;
        tlb_entry_t t;
        @(negedge clk);
        chk(req_ready == 1'b1, "ready_idle", $sformatf("req_ready %0b, need 1", req_ready));
        a = cyc;
        csr_tlbidx = idx; csr_asid = asid; csr_tlb_rdata = cd;
        inv_op = iop; inv_asid = ia; inv_va = iva;
        case (op)
            3'd0: begin
                hit = -1;
                for (int i = TLBNUM - 1; i >= 0; i--)
                    if (srch_match(ref_mem[i], cd.vppn, asid)) hit = i;
                if (hit >= 0) begin
                    push(K_SRCH, a + 1 + hit, hit, 1'b1, '0);
                    push(K_DONE, a + 2 + hit, 0, 1'b0, '0);
                end else begin
                    push(K_SRCH, a + TLBNUM, 0, 1'b0, '0);
                    push(K_DONE, a + TLBNUM + 1, 0, 1'b0, '0);
                end
            end
            3'd1: begin
                push(K_RD, a + 1, 0, 1'b0, ref_mem[idx]);
                push(K_DONE, a + 2, 0, 1'b0, '0);
            end
            3'd2, 3'd3: begin
                widx = (op == 3'd2) ? int'(idx) : (a + 1) % TLBNUM;
                push(K_WR, a + 1, widx, 1'b0, cd);
                ref_mem[widx] = cd;
                push(K_DONE, a + 2, 0, 1'b0, '0);
            end
            3'd4: begin
                n = (abort_at < TLBNUM) ? abort_at : TLBNUM;
                for (int i = 0; i < n; i++)
                    if (inv_pick(ref_mem[i], int'(iop), ia, iva[31:13])) begin
                        t = ref_mem[i];
                        t.e = 1'b0;
                        push(K_WR, a + 1 + i, i, 1'b0, t);
                        ref_mem[i] = t;
                    end
                if (abort_at >= TLBNUM) push(K_DONE, a + 1 + TLBNUM, 0, 1'b0, '0);
            end
            default: push(K_DONE, a + 1, 0, 1'b0, '0);
        endcase
        req_op = op;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_op = 3'($urandom);
        if (abort_at < TLBNUM) begin
            repeat (abort_at) @(posedge clk);
            #1 resetn = 1'b0;
            @(negedge clk);
            check_reset_outputs("abort_reset_outputs");
            @(posedge clk);
            #1 resetn = 1'b1;
            chk(q.size() == 0, "abort_drain", $sformatf("%0d events left, need 0", q.size()));
            repeat (4) @(negedge clk);
            chk(req_ready == 1'b1, "abort_ready", $sformatf("req_ready %0b, need 1", req_ready));
        end else begin
            for (int i = 0; i < 3 * TLBNUM && q.size() != 0; i++) @(negedge clk);
            chk(q.size() == 0, "drain", $sformatf("%0d events left after bound, need 0", q.size()));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tlb_entry_t e5, ent;
        resetn = 1'b0; req_valid = 1'b0; req_op = '0;
        inv_op = '0; inv_asid = '0; inv_va = '0;
        csr_tlbidx = '0; csr_asid = '0; csr_tlb_rdata = '0;
        load_mem(1'b1);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk);
        #1 resetn = 1'b1;

        // Two fills, first accepted with fill_ptr at 0.
        issue(3'd3, 0, 0, 0, 0, 0, rand_entry(1'b1), TLBNUM);
        issue(3'd3, 0, 0, 0, 0, 0, rand_entry(1'b1), TLBNUM);

        // Search hit at entry 5, then the same key with a different ASID misses.
        load_mem(1'b0);
        e5 = '0; e5.e = 1'b1; e5.asid = 10'd3; e5.ps = 6'd12; e5.vppn = 19'h12345;
        e5.ppn0 = 20'hABCDE;
        mem[5] = e5; ref_mem[5] = e5;
        ent = '0; ent.vppn = 19'h12345;
        issue(3'd0, 0, 0, 0, 0, 10'd3, ent, TLBNUM);
        issue(3'd0, 0, 0, 0, 0, 10'd4, ent, TLBNUM);

        // INVTLB op 5 clears only the non-global matching entry.
        load_mem(1'b0);
        ent = '0; ent.e = 1'b1; ent.asid = 10'd3; ent.ps = 6'd12; ent.vppn = 19'h12345;
        mem[2] = ent; ref_mem[2] = ent;
        ent.g = 1'b1; ent.asid = 10'd7;
        mem[9] = ent; ref_mem[9] = ent;
        issue(3'd4, 5'd5, 10'd3, 32'h2468A000, 0, 0, '0, TLBNUM);

        // Read entry 7, then a reserved op.
        load_mem(1'b1);
        issue(3'd1, 0, 0, 0, 4'd7, 0, '0, TLBNUM);
        issue(3'd6, 0, 0, 0, 0, 0, '0, TLBNUM);

        // Reset during an invalidate-all walk at cnt=4.
        issue(3'd4, 5'd0, 0, 0, 0, 0, '0, 4);

        for (int n = 0; n < 40; n++) begin
            if (n % 6 == 0) load_mem(1'b1);
            issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 8)),
                  apool[$urandom_range(0, 2)], {vpool[$urandom_range(0, 3)], 13'($urandom)},
                  4'($urandom), apool[$urandom_range(0, 2)], rand_entry(1'b1), TLBNUM);
        end

        @(negedge clk);
        for (int i = 0; i < TLBNUM; i++)
            chk(mem[i] == ref_mem[i], "array", $sformatf("entry %0d is %h, need %h", i, mem[i], ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
